// File: rtl/vram_arb_pkg.sv
// vram_arb_pkg: shared types and helpers for the VRAM port-A arbiter
// Contents:
//   owner_e      which source owns port A in the current cycle
//   fill_state_e fill engine FSM states
//   be_all_mask  all-ones byte-enable mask for a given word width
package vram_arb_pkg;
    typedef enum logic [1:0] {OWN_NONE, OWN_HOST, OWN_AGENT, OWN_FILL} owner_e;
    typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;
    // Callers truncate the result to DATA_WIDTH/8 bits to get BE_ALL.
    function automatic logic [127:0] be_all_mask(int dw);
        return (128'(1) << (dw / 8)) - 128'(1);
    endfunction
endpackage

// File: rtl/vram_fill_engine.sv
// vram_fill_engine: range fill command FSM and write address generator
// Ports:
//   clk_a, rst            clock, async active-high reset
//   start_i               one-cycle fill command (accepted only when idle)
//   base_i, len_i, value_i  first word, word count (0..2^ADDR_WIDTH), fill word
//   gnt_i                 arbiter accepted the current fill write
//   busy_o                a fill is in progress and requesting port A
//   done_o                one-cycle completion pulse
//   req_addr_o, req_data_o  address and data of the pending fill write
module vram_fill_engine
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_a,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic [DATA_WIDTH-1:0] value_i,
    input  logic                  gnt_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [ADDR_WIDTH-1:0] req_addr_o,
    output logic [DATA_WIDTH-1:0] req_data_o
);
    fill_state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, cnt_q;
    logic [ADDR_WIDTH:0] len_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic done_q, done_d, last;

    always_ff @(posedge clk_a or posedge rst)
        if (rst) state_q <= FILL_IDLE;
        else state_q <= state_d;

    // A zero-length command never enters RUN but still reports completion.
    always_comb begin
        last = {1'b0, cnt_q} == len_q - (ADDR_WIDTH + 1)'(1);
        state_d = state_q == FILL_IDLE ? (start_i && len_i != '0 ? FILL_RUN : FILL_IDLE)
                                       : (gnt_i && last ? FILL_IDLE : FILL_RUN);
        done_d = state_q == FILL_IDLE ? start_i && len_i == '0 : gnt_i && last;
    end

    // Address arithmetic wraps modulo 2^ADDR_WIDTH.
    always_comb begin
        busy_o = state_q == FILL_RUN;
        done_o = done_q;
        req_addr_o = base_q + cnt_q;
        req_data_o = value_q;
    end

    always_ff @(posedge clk_a or posedge rst)
        if (rst) begin
            base_q <= '0;
            len_q <= '0;
            value_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (state_q == FILL_IDLE && start_i) begin
                base_q <= base_i;
                len_q <= len_i;
                value_q <= value_i;
                cnt_q <= '0;
            end else if (state_q == FILL_RUN && gnt_i) begin
                cnt_q <= cnt_q + ADDR_WIDTH'(1);
            end
        end
endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: schedules BRAM port A between host, agent and fill engine
// Ports:
//   clk_a, rst                    clock, async active-high reset
//   h_* / a_*                     host / agent request, grant, one-cycle read return
//   fill_*                        fill command in, busy/done status out
//   bram_we/addr/wdata, bram_rdata  BRAM port A
// Optional macro VRAM_ARB_STATS_EN adds stats_clr and saturating grant
// counters stat_host, stat_agent, stat_fill.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                    clk_a,
    input  logic                    rst,
    input  logic                    h_req,
    input  logic [DATA_WIDTH/8-1:0] h_we,
    input  logic [ADDR_WIDTH-1:0]   h_addr,
    input  logic [DATA_WIDTH-1:0]   h_wdata,
    output logic                    h_gnt,
    output logic                    h_rvalid,
    output logic [DATA_WIDTH-1:0]   h_rdata,
    input  logic                    a_req,
    input  logic [DATA_WIDTH/8-1:0] a_we,
    input  logic [ADDR_WIDTH-1:0]   a_addr,
    input  logic [DATA_WIDTH-1:0]   a_wdata,
    output logic                    a_gnt,
    output logic                    a_rvalid,
    output logic [DATA_WIDTH-1:0]   a_rdata,
    input  logic                    fill_start,
    input  logic [ADDR_WIDTH-1:0]   fill_base,
    input  logic [ADDR_WIDTH:0]     fill_len,
    input  logic [DATA_WIDTH-1:0]   fill_value,
    output logic                    fill_busy,
    output logic                    fill_done,
`ifdef VRAM_ARB_STATS_EN
    input  logic                    stats_clr,
    output logic [31:0]             stat_host,
    output logic [31:0]             stat_agent,
    output logic [31:0]             stat_fill,
`endif
    output logic [DATA_WIDTH/8-1:0] bram_we,
    output logic [ADDR_WIDTH-1:0]   bram_addr,
    output logic [DATA_WIDTH-1:0]   bram_wdata,
    input  logic [DATA_WIDTH-1:0]   bram_rdata
);
    localparam int BW = DATA_WIDTH / 8;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [BW-1:0] BE_ALL = BW'(be_all_mask(DATA_WIDTH));

    owner_e owner;
    logic forced, tie;
    logic last_host_q, last_host_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [ADDR_WIDTH-1:0] addr_q, fill_addr;
    logic [DATA_WIDTH-1:0] wdata_q, fill_data;
    logic h_rv_q, a_rv_q;

    vram_fill_engine #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_fill (
        .clk_a     (clk_a),
        .rst       (rst),
        .start_i   (fill_start),
        .base_i    (fill_base),
        .len_i     (fill_len),
        .value_i   (fill_value),
        .gnt_i     (owner == OWN_FILL),
        .busy_o    (fill_busy),
        .done_o    (fill_done),
        .req_addr_o(fill_addr),
        .req_data_o(fill_data)
    );

    // last_host_q==0 means the agent won the last tie, so the host takes the
    // first tie after reset. Only ties move the round-robin pointer.
    always_comb begin
        forced = fill_busy && starve_q == SW'(STARVE_LIMIT);
        tie = h_req && a_req;
        owner = rst ? OWN_NONE
              : forced ? OWN_FILL
              : tie ? (last_host_q ? OWN_AGENT : OWN_HOST)
              : h_req ? OWN_HOST
              : a_req ? OWN_AGENT
              : fill_busy ? OWN_FILL : OWN_NONE;
        last_host_d = tie && !forced ? owner == OWN_HOST : last_host_q;
        starve_d = !fill_busy || owner == OWN_FILL ? '0 : starve_q + SW'(1);
        h_gnt = owner == OWN_HOST;
        a_gnt = owner == OWN_AGENT;
    end

    // Idle cycles keep the previous address/data on the bus.
    always_comb begin
        bram_we = owner == OWN_HOST ? h_we : owner == OWN_AGENT ? a_we
                : owner == OWN_FILL ? BE_ALL : '0;
        bram_addr = owner == OWN_HOST ? h_addr : owner == OWN_AGENT ? a_addr
                  : owner == OWN_FILL ? fill_addr : addr_q;
        bram_wdata = owner == OWN_HOST ? h_wdata : owner == OWN_AGENT ? a_wdata
                   : owner == OWN_FILL ? fill_data : wdata_q;
        h_rvalid = h_rv_q;
        a_rvalid = a_rv_q;
        h_rdata = bram_rdata;
        a_rdata = bram_rdata;
    end

    always_ff @(posedge clk_a or posedge rst)
        if (rst) begin
            last_host_q <= 1'b0;
            starve_q <= '0;
            addr_q <= '0;
            wdata_q <= '0;
            h_rv_q <= 1'b0;
            a_rv_q <= 1'b0;
        end else begin
            last_host_q <= last_host_d;
            starve_q <= starve_d;
            addr_q <= bram_addr;
            wdata_q <= bram_wdata;
            h_rv_q <= owner == OWN_HOST && h_we == '0;
            a_rv_q <= owner == OWN_AGENT && a_we == '0;
        end

`ifdef VRAM_ARB_STATS_EN
    logic [31:0] st_h_q, st_a_q, st_f_q;

    always_ff @(posedge clk_a or posedge rst)
        if (rst || stats_clr) begin
            st_h_q <= '0;
            st_a_q <= '0;
            st_f_q <= '0;
        end else begin
            if (owner == OWN_HOST && st_h_q != '1) st_h_q <= st_h_q + 32'd1;
            if (owner == OWN_AGENT && st_a_q != '1) st_a_q <= st_a_q + 32'd1;
            if (owner == OWN_FILL && st_f_q != '1) st_f_q <= st_f_q + 32'd1;
        end

    assign stat_host = st_h_q;
    assign stat_agent = st_a_q;
    assign stat_fill = st_f_q;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: table-driven check of arbitration, fill and read return
module tb_vram_arbiter;
    logic clk_a = 1'b0;
    logic rst;
    logic h_req, a_req, h_gnt, a_gnt, h_rvalid, a_rvalid;
    logic [3:0] h_we, a_we, bram_we;
    logic [15:0] h_addr, a_addr, fill_base, bram_addr;
    logic [31:0] h_wdata, a_wdata, h_rdata, a_rdata, fill_value, bram_wdata, bram_rdata;
    logic fill_start, fill_busy, fill_done;
    logic [16:0] fill_len;
    logic [31:0] mem [0:65535];
    int checks = 0;
    int errors = 0;

    typedef struct {
        string name;
        logic hr; logic [3:0] hw; logic [15:0] ha;
        logic ar; logic [3:0] aw; logic [15:0] aa;
        logic fs; logic [15:0] fb; logic [16:0] fl; logic [31:0] fv;
        logic ehg; logic eag; logic [3:0] ewe; logic [15:0] eaddr; logic [31:0] ewd;
        logic ehrv; logic earv; logic [31:0] erd; logic ebusy; logic edone;
    } vec_t;
    vec_t vq[$];

    always #5 clk_a = ~clk_a;

    vram_arbiter dut (
        .clk_a(clk_a), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .fill_start(fill_start), .fill_base(fill_base), .fill_len(fill_len),
        .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_wdata(bram_wdata),
        .bram_rdata(bram_rdata)
    );

    // Read-first BRAM port A model with byte enables.
    always @(posedge clk_a) begin
        bram_rdata <= mem[bram_addr];
        if (|bram_we)
            mem[bram_addr] <= {bram_we[3] ? bram_wdata[31:24] : mem[bram_addr][31:24],
                               bram_we[2] ? bram_wdata[23:16] : mem[bram_addr][23:16],
                               bram_we[1] ? bram_wdata[15:8]  : mem[bram_addr][15:8],
                               bram_we[0] ? bram_wdata[7:0]   : mem[bram_addr][7:0]};
    end

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drv(logic [31:0] hr, logic [31:0] hw, logic [31:0] ha,
                       logic [31:0] ar, logic [31:0] aw, logic [31:0] aa,
                       logic [31:0] fs, logic [31:0] fb, logic [31:0] fl, logic [31:0] fv);
        h_req = hr[0]; h_we = hw[3:0]; h_addr = ha[15:0]; h_wdata = {16'hA5A5, ha[15:0]};
        a_req = ar[0]; a_we = aw[3:0]; a_addr = aa[15:0]; a_wdata = {16'h5A5A, aa[15:0]};
        fill_start = fs[0]; fill_base = fb[15:0]; fill_len = fl[16:0]; fill_value = fv;
    endtask

    task automatic add(string n, logic [31:0] hr, logic [31:0] hw, logic [31:0] ha,
                       logic [31:0] ar, logic [31:0] aw, logic [31:0] aa,
                       logic [31:0] fs, logic [31:0] fb, logic [31:0] fl, logic [31:0] fv,
                       logic [31:0] ehg, logic [31:0] eag, logic [31:0] ewe,
                       logic [31:0] eaddr, logic [31:0] ewd,
                       logic [31:0] ehrv, logic [31:0] earv, logic [31:0] erd,
                       logic [31:0] ebusy, logic [31:0] edone);
        vec_t v;
        v.name = n;
        v.hr = hr[0]; v.hw = hw[3:0]; v.ha = ha[15:0];
        v.ar = ar[0]; v.aw = aw[3:0]; v.aa = aa[15:0];
        v.fs = fs[0]; v.fb = fb[15:0]; v.fl = fl[16:0]; v.fv = fv;
        v.ehg = ehg[0]; v.eag = eag[0]; v.ewe = ewe[3:0]; v.eaddr = eaddr[15:0]; v.ewd = ewd;
        v.ehrv = ehrv[0]; v.earv = earv[0]; v.erd = erd; v.ebusy = ebusy[0]; v.edone = edone[0];
        vq.push_back(v);
    endtask

    initial begin
        mem[16'h0010] = 32'hDEADBEEF;
        mem[16'h0020] = 32'h20202020; mem[16'h0021] = 32'h21212121; mem[16'h0022] = 32'h22222222;
        mem[16'h0030] = 32'h30303030; mem[16'h0031] = 32'h31313131;
        mem[16'h0040] = 32'hFFFFFFFF; mem[16'h0050] = 32'h50505050;

        //   name     hr hw ha      ar aw aa      fs fb       fl fv            hg ag we  addr     wdata         hrv arv rdata        busy done
        add("h_rd",   1, 0, 'h10,   0, 0, 0,      0, 0,       0, 0,            1, 0, 0,  'h10,    0,            0, 0, 0,             0, 0);
        add("h_rv",   0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            1, 0, 'hDEADBEEF,    0, 0);
        add("rr_h0",  1, 0, 'h20,   1, 0, 'h30,   0, 0,       0, 0,            1, 0, 0,  'h20,    0,            0, 0, 0,             0, 0);
        add("rr_a0",  1, 0, 'h21,   1, 0, 'h30,   0, 0,       0, 0,            0, 1, 0,  'h30,    0,            1, 0, 'h20202020,    0, 0);
        add("rr_h1",  1, 0, 'h21,   1, 0, 'h31,   0, 0,       0, 0,            1, 0, 0,  'h21,    0,            0, 1, 'h30303030,    0, 0);
        add("rr_a1",  1, 0, 'h22,   1, 0, 'h31,   0, 0,       0, 0,            0, 1, 0,  'h31,    0,            1, 0, 'h21212121,    0, 0);
        add("rr_h2",  1, 0, 'h22,   0, 0, 0,      0, 0,       0, 0,            1, 0, 0,  'h22,    0,            0, 1, 'h31313131,    0, 0);
        add("rr_end", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            1, 0, 'h22222222,    0, 0);
        add("h_wr",   1, 3, 'h40,   0, 0, 0,      0, 0,       0, 0,            1, 0, 3,  'h40,    'hA5A50040,   0, 0, 0,             0, 0);
        add("a_wr",   0, 0, 0,      1, 15, 'h41,  0, 0,       0, 0,            0, 1, 15, 'h41,    'h5A5A0041,   0, 0, 0,             0, 0);
        add("h_rd40", 1, 0, 'h40,   0, 0, 0,      0, 0,       0, 0,            1, 0, 0,  'h40,    0,            0, 0, 0,             0, 0);
        add("a_rd41", 0, 0, 0,      1, 0, 'h41,   0, 0,       0, 0,            0, 1, 0,  'h41,    0,            1, 0, 'hFFFF0040,    0, 0);
        add("a_rv41", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            0, 1, 'h5A5A0041,    0, 0);
        add("f_st",   0, 0, 0,      0, 0, 0,      1, 'hFFFE,  4, 0,            0, 0, 0,  0,       0,            0, 0, 0,             0, 0);
        add("f_w0",   0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 15, 'hFFFE,  0,            0, 0, 0,             1, 0);
        add("f_w1",   0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 15, 'hFFFF,  0,            0, 0, 0,             1, 0);
        add("f_w2",   0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 15, 'h0000,  0,            0, 0, 0,             1, 0);
        add("f_w3",   0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 15, 'h0001,  0,            0, 0, 0,             1, 0);
        add("f_done", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            0, 0, 0,             0, 1);
        add("f_idle", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            0, 0, 0,             0, 0);
        add("z_st",   0, 0, 0,      0, 0, 0,      1, 'h500,   0, 'h99,         0, 0, 0,  0,       0,            0, 0, 0,             0, 0);
        add("z_done", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            0, 0, 0,             0, 1);
        add("i_st",   0, 0, 0,      0, 0, 0,      1, 'h100,   2, 'h12345678,   0, 0, 0,  0,       0,            0, 0, 0,             0, 0);
        add("i_w0",   0, 0, 0,      0, 0, 0,      1, 'h200,   5, 'hFFFFFFFF,   0, 0, 15, 'h100,   'h12345678,   0, 0, 0,             1, 0);
        add("i_w1",   0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 15, 'h101,   'h12345678,   0, 0, 0,             1, 0);
        add("i_done", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            0, 0, 0,             0, 1);
        add("i_idle", 0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            0, 0, 0,             0, 0);
        add("s_st",   1, 0, 'h50,   0, 0, 0,      1, 'h300,   3, 'hCAFEF00D,   1, 0, 0,  'h50,    0,            0, 0, 0,             0, 0);
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 8; k++)
                add($sformatf("s_h%0d_%0d", r, k), 1, 0, 'h50, 0, 0, 0, 0, 0, 0, 0,
                    1, 0, 0, 'h50, 0, (k == 0 && r > 0) ? 0 : 1, 0, 'h50505050, 1, 0);
            add($sformatf("s_f%0d", r), 1, 0, 'h50, 0, 0, 0, 0, 0, 0, 0,
                0, 0, 15, 'h300 + r, 'hCAFEF00D, 1, 0, 'h50505050, 1, 0);
        end
        add("s_done", 1, 0, 'h50,   0, 0, 0,      0, 0,       0, 0,            1, 0, 0,  'h50,    0,            0, 0, 0,             0, 1);
        add("s_end",  0, 0, 0,      0, 0, 0,      0, 0,       0, 0,            0, 0, 0,  0,       0,            1, 0, 'h50505050,    0, 0);

        rst = 1'b1;
        drv(1, 0, 'h10, 1, 0, 'h20, 1, 'h10, 4, 0);
        repeat (2) @(negedge clk_a);
        #1;
        chk("rst_hgnt", 32'(h_gnt), 0);
        chk("rst_agnt", 32'(a_gnt), 0);
        chk("rst_we", 32'(bram_we), 0);
        chk("rst_busy", 32'(fill_busy), 0);
        chk("rst_done", 32'(fill_done), 0);
        chk("rst_rv", 32'({h_rvalid, a_rvalid}), 0);
        @(negedge clk_a);
        rst = 1'b0;
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vq[i]) begin
            @(negedge clk_a);
            drv(32'(vq[i].hr), 32'(vq[i].hw), 32'(vq[i].ha), 32'(vq[i].ar), 32'(vq[i].aw),
                32'(vq[i].aa), 32'(vq[i].fs), 32'(vq[i].fb), 32'(vq[i].fl), vq[i].fv);
            #1;
            chk({vq[i].name, ".h_gnt"}, 32'(h_gnt), 32'(vq[i].ehg));
            chk({vq[i].name, ".a_gnt"}, 32'(a_gnt), 32'(vq[i].eag));
            chk({vq[i].name, ".we"}, 32'(bram_we), 32'(vq[i].ewe));
            if (vq[i].ehg || vq[i].eag || vq[i].ewe != 4'h0)
                chk({vq[i].name, ".addr"}, 32'(bram_addr), 32'(vq[i].eaddr));
            if (vq[i].ewe != 4'h0) chk({vq[i].name, ".wdata"}, bram_wdata, vq[i].ewd);
            chk({vq[i].name, ".h_rvalid"}, 32'(h_rvalid), 32'(vq[i].ehrv));
            chk({vq[i].name, ".a_rvalid"}, 32'(a_rvalid), 32'(vq[i].earv));
            if (vq[i].ehrv) chk({vq[i].name, ".h_rdata"}, h_rdata, vq[i].erd);
            if (vq[i].earv) chk({vq[i].name, ".a_rdata"}, a_rdata, vq[i].erd);
            chk({vq[i].name, ".busy"}, 32'(fill_busy), 32'(vq[i].ebusy));
            chk({vq[i].name, ".done"}, 32'(fill_done), 32'(vq[i].edone));
        end

        // Leave the host as last tie winner, then abort a fill with reset.
        @(negedge clk_a); drv(1, 0, 'h60, 1, 0, 'h70, 0, 0, 0, 0); #1;
        chk("pre_tie_h", 32'(h_gnt), 1);
        chk("pre_tie_a", 32'(a_gnt), 0);
        @(negedge clk_a); drv(0, 0, 0, 1, 0, 'h70, 0, 0, 0, 0); #1;
        chk("pre_solo_a", 32'(a_gnt), 1);
        @(negedge clk_a); drv(0, 0, 0, 0, 0, 0, 1, 'h400, 10, 'h77); #1;
        chk("rf_start_arv", 32'(a_rvalid), 1);
        @(negedge clk_a); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rf_w0_we", 32'(bram_we), 'hF);
        chk("rf_w0_addr", 32'(bram_addr), 'h400);
        @(negedge clk_a); #1;
        chk("rf_w1_addr", 32'(bram_addr), 'h401);
        @(negedge clk_a); drv(1, 0, 'h10, 0, 0, 0, 0, 0, 0, 0); #1;
        chk("rf_hgnt", 32'(h_gnt), 1);
        chk("rf_busy", 32'(fill_busy), 1);
        @(negedge clk_a); drv(1, 0, 'h10, 1, 0, 'h70, 0, 0, 0, 0); #1;
        chk("rf_hrv_pre", 32'(h_rvalid), 1);
        chk("rf_hrd_pre", h_rdata, 'hDEADBEEF);
        #1 rst = 1'b1;
        #1;
        chk("rf_rst_hrv", 32'(h_rvalid), 0);
        chk("rf_rst_busy", 32'(fill_busy), 0);
        chk("rf_rst_gnt", 32'({h_gnt, a_gnt}), 0);
        chk("rf_rst_we", 32'(bram_we), 0);
        chk("rf_rst_done", 32'(fill_done), 0);
        repeat (2) begin
            @(negedge clk_a); #1;
            chk("rf_hold_done", 32'(fill_done), 0);
            chk("rf_hold_gnt", 32'({h_gnt, a_gnt}), 0);
        end
        @(negedge clk_a); rst = 1'b0; #1;
        chk("post_tie_h", 32'(h_gnt), 1);
        chk("post_tie_a", 32'(a_gnt), 0);
        @(negedge clk_a); drv(0, 0, 0, 1, 0, 'h70, 0, 0, 0, 0); #1;
        chk("post_solo_a", 32'(a_gnt), 1);
        @(negedge clk_a); drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) begin
            #1;
            chk("post_done", 32'(fill_done), 0);
            chk("post_busy", 32'(fill_busy), 0);
            chk("post_we", 32'(bram_we), 0);
            @(negedge clk_a);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Schedules port A of the dual-port video BRAM (clk_a domain) between three sources: the host bus, a secondary agent (text/sprite renderer), and an internal fill engine that clears or paints address ranges. Port B stays dedicated to scan-out.
- Round-robin arbitration between host and agent.
- Fill writes go into idle slots, with a starvation guarantee.
- Fixed one-cycle read return.

Parameters:
- ADDR_WIDTH, 16, BRAM word-address width
- DATA_WIDTH, 32, BRAM word width; must be a multiple of 8
- STARVE_LIMIT, 8, consecutive denied cycles after which the fill engine is forced one slot

Ports:
- clk_a  in  1  clock (BRAM port-A clock)
- rst  in  1  reset, asynchronous, active-high
- h_req  in  1  host access request
- h_we  in  DATA_WIDTH/8  host byte write enables; all-zero means read
- h_addr  in  ADDR_WIDTH  host word address
- h_wdata  in  DATA_WIDTH  host write data
- h_gnt  out  1  host access accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  DATA_WIDTH  host read data
- a_req, a_we, a_addr, a_wdata, a_gnt, a_rvalid, a_rdata: agent port, same widths and semantics as the host port
- fill_start  in  1  one-cycle fill command
- fill_base  in  ADDR_WIDTH  first word to write
- fill_len  in  ADDR_WIDTH+1  number of words to write
- fill_value  in  DATA_WIDTH  fill word
- fill_busy  out  1  fill in progress
- fill_done  out  1  one-cycle completion pulse
- bram_we  out  DATA_WIDTH/8  to BRAM we_a
- bram_addr  out  ADDR_WIDTH  to BRAM addr_a
- bram_wdata  out  DATA_WIDTH  to BRAM write_a
- bram_rdata  in  DATA_WIDTH  from BRAM read_a

Behaviour:
- Grants are combinational in the request cycle. The winner's we/addr/wdata are muxed onto the bram_* outputs in the same cycle.
- With no winner, bram_we=0. bram_addr and bram_wdata hold their last values and are don't-care.
- Requester holds req/we/addr/wdata stable until gnt. A request is consumed on the cycle req && gnt.
- Priority, evaluated each cycle:
  1. Forced fill: fill_busy && starve_cnt==STARVE_LIMIT. Fill wins, h_gnt=a_gnt=0.
  2. Host or agent requesting:
     - Exactly one requests: it wins.
     - Both request: grant the one that is not last_winner; update last_winner.
  3. Fill wins if fill_busy.
- Reset values: last_winner=AGENT (host wins the first tie), starve_cnt=0.
- starve_cnt:
  - Increments on each cycle fill_busy && fill not granted.
  - Clears on any fill grant.
  - Stays 0 while idle.
- Read return: a granted access with we==0 asserts the owner's rvalid in the next cycle, with rdata=bram_rdata.
  - Write grants produce no rvalid.
  - Back-to-back reads give back-to-back rvalid.
  - rdata is don't-care when rvalid=0.
- Fill FSM, states IDLE and RUN:
  - IDLE, fill_start, fill_len!=0: latch base/len/value, cnt=0, go to RUN, fill_busy=1 from the next cycle.
  - IDLE, fill_start, fill_len==0: no writes; fill_done pulses the next cycle.
  - RUN, each fill grant: bram_we=all-ones, bram_addr=base+cnt (modulo 2^ADDR_WIDTH, wraps), bram_wdata=value, cnt++.
  - On the grant where cnt==len-1: go to IDLE; fill_done=1 and fill_busy=0 in the next cycle.
  - fill_start while fill_busy is ignored.
  - fill_len max 2^ADDR_WIDTH covers the full memory.
- Async rst: all registered outputs and state go 0 immediately and grants are 0 while rst=1. A fill in progress is aborted with no fill_done. Pending rvalid is dropped.
- Simultaneous fill_start and host/agent requests: the command latches regardless. The fill competes from the next cycle.

Optional Feature:
- Macro VRAM_ARB_STATS_EN.
- Defined: adds inputs stats_clr (1) and outputs stat_host (32), stat_agent (32), stat_fill (32).
  - Each counter counts its source's grants and saturates at 2^32-1.
  - Cleared by rst or stats_clr; stats_clr has priority over a same-cycle increment.
- Undefined: the ports and counters do not exist. Arbitration behaviour is identical.

Decomposition:
- Package vram_arb_pkg:
  - owner_e {OWN_NONE, OWN_HOST, OWN_AGENT, OWN_FILL}
  - fill_state_e {FILL_IDLE, FILL_RUN}
  - localparam BE_ALL function of DATA_WIDTH
- Sub-module vram_fill_engine:
  - Contains the FSM, latched command, counter and address generation.
  - Exposes busy, done, req_addr, req_data, and a grant input.
  - The arbiter top owns the mux, round-robin state, starvation counter and the rvalid pipeline.

Test Plan:
- Host read addr 0x0010, BRAM preloaded 0xDEADBEEF → h_gnt same cycle, h_rvalid next cycle with h_rdata=0xDEADBEEF, a_rvalid=0.
- Host and agent both request every cycle for 4 cycles → grants H,A,H,A; every read gets rvalid exactly one cycle later on the correct port.
- fill_start base=0xFFFE len=4 value=0x00000000, no other traffic → writes at 0xFFFE, 0xFFFF, 0x0000, 0x0001 on consecutive cycles; fill_done pulses once; fill_busy is high for exactly 4 cycles.
- Fill len=3 while host requests continuously (STARVE_LIMIT=8) → host granted 8 cycles, fill forced on cycle 9, pattern repeats; fill_done after 3 fill writes.
- fill_len=0 → no bram_we, fill_done one cycle after fill_start. fill_start while busy → ignored, only one fill_done.
- rst asserted mid-fill after 2 of 10 writes → outputs 0 at once, no fill_done. After release a host tie with the agent goes to the host first.
